// File: rtl/uart_rs232_tx.sv
// RS-232 UART transmitter: start, 6/7/8 data bits LSB first, one stop bit.
// Define UART_TX_PARITY_EN to append an even parity bit after the data.
module uart_rs232_tx #(
    parameter int TICKS_PER_BIT = 16
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Tick,
    input  logic       TxEn,
    input  logic       TxStart,
    input  logic [7:0] TxData,
    input  logic [3:0] NBits,
    output logic       Tx,
    output logic       TxBusy,
    output logic       TxDone
);

    localparam int TW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [2:0]      bit_q, bit_d;
    logic [2:0]      last_q, last_d;
    logic [7:0]      data_q, data_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            bit_end;
    logic [2:0]      next_bit;
`ifdef UART_TX_PARITY_EN
    logic [7:0]      mask;
`endif

    assign bit_end  = Tick && (tick_q == TW'(TICKS_PER_BIT - 1));
    assign next_bit = bit_q + 3'd1;
`ifdef UART_TX_PARITY_EN
    assign mask     = 8'hFF >> (3'd7 - last_q);
`endif

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        last_d  = last_q;
        data_d  = data_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (Tick && state_q != S_IDLE) begin
            tick_d = tick_q + TW'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                if (TxStart && TxEn) begin
                    state_d = S_START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    data_d  = TxData;
                    tick_d  = '0;
                    bit_d   = '0;
                    // Any width other than 6 or 7 falls back to 8 bits
                    last_d  = (NBits == 4'd6) ? 3'd5 :
                              (NBits == 4'd7) ? 3'd6 : 3'd7;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    tx_d    = data_q[0];
                    tick_d  = '0;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    tick_d = '0;
                    if (bit_q == last_q) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = ^(data_q & mask);
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d = next_bit;
                        tx_d  = data_q[next_bit];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                    tick_d  = '0;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    tick_d  = '0;
                    bit_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            last_q  <= '0;
            data_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            last_q  <= last_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Tx     = tx_q;
    assign TxBusy = busy_q;
    assign TxDone = done_q;

endmodule

// File: doc/uart_rs232_tx.md
UART_RS232_TX -- requirements
Module: uart_rs232_tx

Interface
REQ-001 SHALL have parameter TICKS_PER_BIT, default 16: number of Tick pulses per serial bit period.
REQ-002 SHALL have port Clk  input  1  system clock; all state updates occur on rising edge.
REQ-003 SHALL have port Rst_n  input  1  reset; one clock, asynchronous, active-low.
REQ-004 SHALL have port Tick  input  1  baud enable, one Clk cycle wide, TICKS_PER_BIT per bit period.
REQ-005 SHALL have port TxEn  input  1  transmitter enable; gates acceptance of new frames only.
REQ-006 SHALL have port TxStart  input  1  frame request, level-sampled on Clk.
REQ-007 SHALL have port TxData  input  8  data to send, LSB first.
REQ-008 SHALL have port NBits  input  4  data bits per frame: 6, 7 or 8.
REQ-009 SHALL have port Tx  output  1  serial line, idle high.
REQ-010 SHALL have port TxBusy  output  1  high while a frame is in progress.
REQ-011 SHALL have port TxDone  output  1  one-Clk pulse at frame completion.

Function
REQ-012 SHALL be fully synchronous to Clk; Tick is an enable only, never a clock.
REQ-013 SHALL implement states IDLE, START, DATA, PARITY (only if REQ-027 applies), STOP.
REQ-014 IDLE -> START when TxStart & TxEn & state==IDLE on a Clk edge; TxData and NBits latched on that edge.
REQ-015 Tx SHALL go low on the Clk edge that accepts the frame (zero-cycle latency to start bit).
REQ-016 Each of START, each DATA bit, PARITY, STOP SHALL hold Tx for exactly TICKS_PER_BIT Tick pulses counted after entering the state.
REQ-017 DATA SHALL send latched bits [0..N-1] LSB first, N = latched NBits; NBits values other than 6/7 SHALL be treated as 8.
REQ-018 STOP SHALL drive Tx high for one bit period, then return to IDLE.
REQ-019 TxDone SHALL pulse high for exactly one Clk in the first cycle in IDLE after STOP.
REQ-020 TxStart in the TxDone cycle SHALL be accepted (back-to-back frames, no idle gap).
REQ-021 TxBusy SHALL be high from the accepting edge until the edge entering IDLE.
REQ-022 TxStart while TxBusy SHALL be ignored; no queuing.
REQ-023 Changes to TxData/NBits after acceptance SHALL not affect the frame in flight.
REQ-024 TxEn deasserted mid-frame SHALL not abort; frame completes normally.

Reset
REQ-025 On Rst_n low, asynchronously: state=IDLE, Tx=1, TxBusy=0, TxDone=0, tick and bit counters=0, latched data=0.
REQ-026 Reset mid-frame SHALL abort the frame with no TxDone; first frame after release behaves as from power-up.

Configuration
REQ-027 With macro UART_TX_PARITY_EN defined, a PARITY bit SHALL follow the last data bit: even parity over the N sent data bits.
REQ-028 Without UART_TX_PARITY_EN, no PARITY state or logic SHALL exist; DATA -> STOP directly.

Verification
REQ-029 8N1, TxData=0x55, NBits=8, no parity: Tx = 0,1,0,1,0,1,0,1,0,1 each 16 Ticks; TxDone after 160 Ticks.
REQ-030 NBits=7, TxData=0xA5: data bits 1,0,1,0,0,1,0; frame 144 Ticks; bit 7 never sent.
REQ-031 UART_TX_PARITY_EN, NBits=8, TxData=0x07: parity bit 1; frame 176 Ticks; TxData=0x55 -> parity 0.
REQ-032 TxStart held high across two frames (0x12 then 0x34): second start bit begins in TxDone cycle, no idle bit.
REQ-033 Rst_n low at Tick 70 of a frame: Tx=1, TxBusy=0 immediately, no TxDone; next frame 0xF0 correct.
REQ-034 TxStart pulsed mid-frame and TxData changed: ignored; in-flight frame bits unchanged.
